// File: rtl/sprite_pkg.sv
// Shared sprite dimensions, bus widths and the layer encoding for the
// frog/car/log compositor.
package sprite_pkg;

  localparam int FROG_W  = 28;
  localparam int FROG_H  = 28;
  localparam int CAR_W   = 56;
  localparam int CAR_H   = 28;
  localparam int LOG_W   = 112;
  localparam int LOG_H   = 28;

  localparam int ADDR_W  = 19;
  localparam int IDX_W   = 5;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    LAYER_BG   = 2'd0,
    LAYER_LOG  = 2'd1,
    LAYER_CAR  = 2'd2,
    LAYER_FROG = 2'd3
  } layer_e;

endpackage

// File: rtl/sprite_hit.sv
// Combinational box test for one W x H sprite: reports whether the draw
// position lies inside the sprite and the row-major local address if so.
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic               en,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic [COORD_W-1:0] loc_x;
  logic [COORD_W-1:0] loc_y;

  always_comb begin
    // One extra bit so objects near the right/bottom edge never wrap.
    x_end = {1'b0, obj_x} + (COORD_W+1)'(W);
    y_end = {1'b0, obj_y} + (COORD_W+1)'(H);
    hit   = en
          && (draw_x >= obj_x) && ({1'b0, draw_x} < x_end)
          && (draw_y >= obj_y) && ({1'b0, draw_y} < y_end);
    loc_x = draw_x - obj_x;
    loc_y = draw_y - obj_y;
    addr  = '0;
    if (hit) begin
      addr = ADDR_W'(loc_y) * ADDR_W'(W) + ADDR_W'(loc_x);
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel pipeline: stage 1 drives the sprite RAM addresses, stage 2
// resolves transparency/priority; also accumulates per-frame overlap flags.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int               NUM_CARS    = 4,
  parameter int               NUM_LOGS    = 4,
  parameter logic [IDX_W-1:0] TRANSPARENT = 5'h00
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  input  logic                         draw_valid,
  input  logic [COORD_W-1:0]           frog_x,
  input  logic [COORD_W-1:0]           frog_y,
  input  logic                         frog_en,
  input  logic [NUM_CARS*COORD_W-1:0]  car_x,
  input  logic [NUM_CARS*COORD_W-1:0]  car_y,
  input  logic [NUM_CARS-1:0]          car_en,
  input  logic [NUM_LOGS*COORD_W-1:0]  log_x,
  input  logic [NUM_LOGS*COORD_W-1:0]  log_y,
  input  logic [NUM_LOGS-1:0]          log_en,
  output logic [ADDR_W-1:0]            frog_addr,
  output logic [ADDR_W-1:0]            car_addr,
  output logic [ADDR_W-1:0]            log_addr,
  input  logic [IDX_W-1:0]             frog_data,
  input  logic [IDX_W-1:0]             car_data,
  input  logic [IDX_W-1:0]             log_data,
  output logic [IDX_W-1:0]             pix_index,
  output logic [1:0]                   pix_layer,
  output logic                         pix_valid,
  output logic                         hit_car,
  output logic                         on_log
);

  // Shadow copies of object state, refreshed once per frame.
  logic [COORD_W-1:0]          frog_x_q, frog_x_d;
  logic [COORD_W-1:0]          frog_y_q, frog_y_d;
  logic                        frog_en_q, frog_en_d;
  logic [NUM_CARS*COORD_W-1:0] car_x_q, car_x_d;
  logic [NUM_CARS*COORD_W-1:0] car_y_q, car_y_d;
  logic [NUM_CARS-1:0]         car_en_q, car_en_d;
  logic [NUM_LOGS*COORD_W-1:0] log_x_q, log_x_d;
  logic [NUM_LOGS*COORD_W-1:0] log_y_q, log_y_d;
  logic [NUM_LOGS-1:0]         log_en_q, log_en_d;

  logic                        frog_hit_c;
  logic [ADDR_W-1:0]           frog_addr_c;
  logic [NUM_CARS-1:0]         car_hit_c;
  logic [ADDR_W-1:0]           car_addr_c [NUM_CARS];
  logic [NUM_LOGS-1:0]         log_hit_c;
  logic [ADDR_W-1:0]           log_addr_c [NUM_LOGS];
  logic                        car_sel_hit;
  logic [ADDR_W-1:0]           car_sel_addr;
  logic                        log_sel_hit;
  logic [ADDR_W-1:0]           log_sel_addr;

  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_frog_hit_q, s1_frog_hit_d;
  logic                        s1_car_hit_q, s1_car_hit_d;
  logic                        s1_log_hit_q, s1_log_hit_d;
  logic [ADDR_W-1:0]           s1_frog_addr_q, s1_frog_addr_d;
  logic [ADDR_W-1:0]           s1_car_addr_q, s1_car_addr_d;
  logic [ADDR_W-1:0]           s1_log_addr_q, s1_log_addr_d;

  logic                        frog_opaque, car_opaque, log_opaque;
  logic [IDX_W-1:0]            pix_index_q, pix_index_d;
  layer_e                      pix_layer_q, pix_layer_d;
  logic                        pix_valid_q, pix_valid_d;
  logic                        acc_car_q, acc_car_d;
  logic                        acc_log_q, acc_log_d;
  logic                        hit_car_q, hit_car_d;
  logic                        on_log_q, on_log_d;

  always_comb begin
    frog_x_d  = frog_x_q;
    frog_y_d  = frog_y_q;
    frog_en_d = frog_en_q;
    car_x_d   = car_x_q;
    car_y_d   = car_y_q;
    car_en_d  = car_en_q;
    log_x_d   = log_x_q;
    log_y_d   = log_y_q;
    log_en_d  = log_en_q;
    if (frame_start) begin
      frog_x_d  = frog_x;
      frog_y_d  = frog_y;
      frog_en_d = frog_en;
      car_x_d   = car_x;
      car_y_d   = car_y;
      car_en_d  = car_en;
      log_x_d   = log_x;
      log_y_d   = log_y;
      log_en_d  = log_en;
    end
  end

  sprite_hit #(.W(FROG_W), .H(FROG_H)) u_frog_hit (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .obj_x  (frog_x_q),
    .obj_y  (frog_y_q),
    .en     (frog_en_q),
    .hit    (frog_hit_c),
    .addr   (frog_addr_c)
  );

  generate
    for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
      sprite_hit #(.W(CAR_W), .H(CAR_H)) u_car_hit (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .obj_x  (car_x_q[gi*COORD_W +: COORD_W]),
        .obj_y  (car_y_q[gi*COORD_W +: COORD_W]),
        .en     (car_en_q[gi]),
        .hit    (car_hit_c[gi]),
        .addr   (car_addr_c[gi])
      );
    end
    for (genvar gi = 0; gi < NUM_LOGS; gi++) begin : g_log
      sprite_hit #(.W(LOG_W), .H(LOG_H)) u_log_hit (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .obj_x  (log_x_q[gi*COORD_W +: COORD_W]),
        .obj_y  (log_y_q[gi*COORD_W +: COORD_W]),
        .en     (log_en_q[gi]),
        .hit    (log_hit_c[gi]),
        .addr   (log_addr_c[gi])
      );
    end
  endgenerate

  // Scan from the top index down so the lowest-index hit is the last write.
  always_comb begin
    car_sel_hit  = 1'b0;
    car_sel_addr = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (car_hit_c[i]) begin
        car_sel_hit  = 1'b1;
        car_sel_addr = car_addr_c[i];
      end
    end
    log_sel_hit  = 1'b0;
    log_sel_addr = '0;
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      if (log_hit_c[i]) begin
        log_sel_hit  = 1'b1;
        log_sel_addr = log_addr_c[i];
      end
    end
  end

  always_comb begin
    s1_valid_d     = draw_valid;
    s1_frog_hit_d  = draw_valid && frog_hit_c;
    s1_car_hit_d   = draw_valid && car_sel_hit;
    s1_log_hit_d   = draw_valid && log_sel_hit;
    s1_frog_addr_d = s1_frog_hit_d ? frog_addr_c  : '0;
    s1_car_addr_d  = s1_car_hit_d  ? car_sel_addr : '0;
    s1_log_addr_d  = s1_log_hit_d  ? log_sel_addr : '0;
  end

  always_comb begin
    frog_opaque = s1_frog_hit_q && (frog_data != TRANSPARENT);
    car_opaque  = s1_car_hit_q  && (car_data  != TRANSPARENT);
    log_opaque  = s1_log_hit_q  && (log_data  != TRANSPARENT);

    pix_index_d = '0;
    pix_layer_d = LAYER_BG;
    pix_valid_d = s1_valid_q;
    if (frog_opaque) begin
      pix_index_d = frog_data;
      pix_layer_d = LAYER_FROG;
    end else if (car_opaque) begin
      pix_index_d = car_data;
      pix_layer_d = LAYER_CAR;
    end else if (log_opaque) begin
      pix_index_d = log_data;
      pix_layer_d = LAYER_LOG;
    end

    // The pixel resolving on the frame_start cycle still counts toward the
    // frame that is closing.
    hit_car_d = hit_car_q;
    on_log_d  = on_log_q;
    acc_car_d = acc_car_q || (frog_opaque && car_opaque);
    acc_log_d = acc_log_q || (frog_opaque && log_opaque);
    if (frame_start) begin
      hit_car_d = acc_car_d;
      on_log_d  = acc_log_d;
      acc_car_d = 1'b0;
      acc_log_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frog_x_q       <= '0;
      frog_y_q       <= '0;
      frog_en_q      <= 1'b0;
      car_x_q        <= '0;
      car_y_q        <= '0;
      car_en_q       <= '0;
      log_x_q        <= '0;
      log_y_q        <= '0;
      log_en_q       <= '0;
      s1_valid_q     <= 1'b0;
      s1_frog_hit_q  <= 1'b0;
      s1_car_hit_q   <= 1'b0;
      s1_log_hit_q   <= 1'b0;
      s1_frog_addr_q <= '0;
      s1_car_addr_q  <= '0;
      s1_log_addr_q  <= '0;
      pix_index_q    <= '0;
      pix_layer_q    <= LAYER_BG;
      pix_valid_q    <= 1'b0;
      acc_car_q      <= 1'b0;
      acc_log_q      <= 1'b0;
      hit_car_q      <= 1'b0;
      on_log_q       <= 1'b0;
    end else begin
      frog_x_q       <= frog_x_d;
      frog_y_q       <= frog_y_d;
      frog_en_q      <= frog_en_d;
      car_x_q        <= car_x_d;
      car_y_q        <= car_y_d;
      car_en_q       <= car_en_d;
      log_x_q        <= log_x_d;
      log_y_q        <= log_y_d;
      log_en_q       <= log_en_d;
      s1_valid_q     <= s1_valid_d;
      s1_frog_hit_q  <= s1_frog_hit_d;
      s1_car_hit_q   <= s1_car_hit_d;
      s1_log_hit_q   <= s1_log_hit_d;
      s1_frog_addr_q <= s1_frog_addr_d;
      s1_car_addr_q  <= s1_car_addr_d;
      s1_log_addr_q  <= s1_log_addr_d;
      pix_index_q    <= pix_index_d;
      pix_layer_q    <= pix_layer_d;
      pix_valid_q    <= pix_valid_d;
      acc_car_q      <= acc_car_d;
      acc_log_q      <= acc_log_d;
      hit_car_q      <= hit_car_d;
      on_log_q       <= on_log_d;
    end
  end

  assign frog_addr = s1_frog_addr_q;
  assign car_addr  = s1_car_addr_q;
  assign log_addr  = s1_log_addr_q;
  assign pix_index = pix_index_q;
  assign pix_layer = pix_layer_q;
  assign pix_valid = pix_valid_q;
  assign hit_car   = hit_car_q;
  assign on_log    = on_log_q;

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Pixel-pipeline stage that drives the frog, car and log sprite frame RAMs for the current VGA draw position and resolves their palette indices into one output index per pixel. It sits between the VGA timing counters and the palette/colour mapper. It computes each RAM's read address, captures the combinational RAM outputs, and applies transparency and layer priority. It also accumulates per-frame frog/car and frog/log overlap flags for game logic.

## Interface
Parameters:
- NUM_CARS, 4, number of car objects sharing the car RAM
- NUM_LOGS, 4, number of log objects sharing the log RAM
- TRANSPARENT, 5'h00, palette index treated as see-through

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX, DrawY  in  10 each  current pixel coordinate
- draw_valid  in  1  active-video qualifier for DrawX/DrawY
- frog_x, frog_y  in  10 each  frog top-left
- frog_en  in  1  frog visible
- car_x, car_y  in  NUM_CARS*10 each  packed car top-lefts, car 0 in LSBs
- car_en  in  NUM_CARS  per-car visible
- log_x, log_y  in  NUM_LOGS*10 each  packed log top-lefts
- log_en  in  NUM_LOGS  per-log visible
- frog_addr, car_addr, log_addr  out  19 each  RAM read addresses
- frog_data, car_data, log_data  in  5 each  RAM read data, combinational from the address
- pix_index  out  5  resolved palette index
- pix_layer  out  2  winning layer
- pix_valid  out  1  pix_index corresponds to active video
- hit_car  out  1  frog and car opaque pixels overlapped during the previous frame
- on_log  out  1  frog and log opaque pixels overlapped during the previous frame

## Operation
- Shadow registers hold all position and enable inputs. They load only on the cycle after frame_start is high. Between loads, inputs are ignored, which prevents tearing.
- Sprite sizes are fixed:
  - frog 28x28, address y*28+x, range 0..783
  - car 56x28, address y*56+x, range 0..1567
  - log 112x28, address y*112+x, range 0..3135
- Hit test per object: en && DrawX>=x && DrawX<x+W && DrawY>=y && DrawY<y+H. Compute the sums in 11 bits so they never wrap. Objects extending past 639/479 are clipped naturally.
- With multiple car hits, the lowest index wins. Logs follow the same rule.
- With no hit, or draw_valid low, the type's address is 0 and its hit bit is 0.
- A type is opaque when its hit bit is 1 and its data is not TRANSPARENT.
- Priority is FROG(3) > CAR(2) > LOG(1) > BG(0). BG outputs pix_index=0.
- Accumulators:
  - acc_car sets when frog and car are both opaque on the same pixel.
  - acc_log sets when frog and log are both opaque on the same pixel.
  - On frame_start, hit_car<=acc_car|new term and on_log<=acc_log|new term. Both accumulators clear in that same cycle.

## Timing
- Stage 1 registers on the edge after DrawX/DrawY/draw_valid: hit bits, local addresses, valid.
- Address outputs come directly from stage-1 registers. RAM data is consumed in the same cycle.
- Stage 2 registers the resolved pix_index/pix_layer/pix_valid.
- Total latency is 2 cycles, with one pixel per cycle and no stalls.
- A pixel in flight when frame_start arrives uses the old shadows. Shadows change for inputs sampled from the cycle after frame_start.
- Reset (asynchronous) clears all outputs, pipeline registers, shadows (enables = 0) and accumulators to 0. The pipeline is flushed, and pix_valid stays 0 until a valid pixel has traversed 2 stages.

## Structure
- sprite_pkg holds:
  - FROG_W/H=28, CAR_W=56, CAR_H=28, LOG_W=112, LOG_H=28
  - ADDR_W=19, IDX_W=5, COORD_W=10
  - the layer enum LAYER_BG/LOG/CAR/FROG
- One sub-module, sprite_hit, parameterised by W and H. It is combinational: coordinate plus object position and enable in, hit and local address out. It is instantiated once for the frog, NUM_CARS times and NUM_LOGS times.

## Test plan
- Frog shadow at (100,200): DrawX/Y=(100,200) -> frog_addr=0. DrawX/Y=(127,227) -> frog_addr=783, and 2 cycles later pix_index=frog_data, pix_layer=3. DrawX=128 -> frog hit 0.
- Car0 at (300,50), car1 at (400,50): DrawX/Y=(355,77) -> car_addr=1567. DrawX/Y=(400,50) -> car_addr=0 via car1.
- Frog over car, frog_data=0, car_data=7 -> pix_index=7, pix_layer=2. With frog_data=3 -> pix_index=3, layer 3, and hit_car=1 after the next frame_start. It returns to 0 one frame later if no overlap recurs.
- Change frog_x mid-frame -> the address does not move until the cycle after frame_start.
- draw_valid low with all sprites enabled -> pix_valid=0, pix_index=0, all addresses 0.
- Assert Reset during streaming -> all outputs 0 immediately. After release with valid input, pix_valid=1 exactly 2 cycles later.
